// File: rtl/mem_page_reader.sv
// Data-memory page reader: fetches WORDS_PER_PAGE words per trigger and streams
// each one as ASCII hex characters (MSB nibble first) over a valid/ready link.
module mem_page_reader #(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    WORDS_PER_PAGE = 4,
  parameter int                    ADDR_STEP      = 1,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int                    MEM_LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  trigger_in,
  input  logic                  page_reset_in,
  output logic                  mem_rd_en_out,
  output logic [ADDR_WIDTH-1:0] mem_addr_out,
  input  logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  char_valid_out,
  output logic [7:0]            char_data_out,
  output logic                  char_last_out,
  input  logic                  char_ready_in,
  output logic                  busy_out,
  output logic [ADDR_WIDTH-1:0] page_addr_out,
  output logic [1:0]            state_dbg
);

  // Character handshake: a character transfers on a rising clk edge where
  // char_valid_out && char_ready_in. Once valid is raised, char_data_out and
  // char_last_out hold until that transfer; valid never drops without ready.

  localparam int NIBBLES = DATA_WIDTH / 4;
  localparam int NIB_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam int WIDX_W  = (WORDS_PER_PAGE > 1) ? $clog2(WORDS_PER_PAGE) : 1;
  localparam int LAT_W   = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  localparam logic [NIB_W-1:0]      LAST_NIB  = NIB_W'(NIBBLES - 1);
  localparam logic [WIDX_W-1:0]     LAST_WORD = WIDX_W'(WORDS_PER_PAGE - 1);
  localparam logic [LAT_W-1:0]      LAST_WAIT = LAT_W'(MEM_LATENCY - 1);
  localparam logic [ADDR_WIDTH-1:0] STEP_A    = ADDR_WIDTH'(ADDR_STEP);
  localparam logic [ADDR_WIDTH-1:0] PAGE_INC  = ADDR_WIDTH'(WORDS_PER_PAGE * ADDR_STEP);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_EMIT = 2'd3
  } state_t;

  state_t                state;
  logic                  trig_q;
  logic                  trig_prev;
  logic                  page_reset_q;
  logic [WIDX_W-1:0]     word_idx;
  logic [NIB_W-1:0]      nib_idx;
  logic [NIB_W-1:0]      nib_inc;
  logic [LAT_W-1:0]      wait_cnt;
  logic [DATA_WIDTH-1:0] word_q;
  logic [DATA_WIDTH-1:0] word_shift;
  logic                  trig_edge;
  logic                  last_word;
  logic                  last_nib;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return 8'h37 + {4'h0, n};
  endfunction

  // Trigger and page reset share one register stage so that, seen from the
  // FSM, inputs raised in the same cycle arrive in the same cycle.
  assign trig_edge  = trig_q & ~trig_prev;
  assign last_word  = (word_idx == LAST_WORD);
  assign last_nib   = (nib_idx == LAST_NIB);
  assign nib_inc    = nib_idx + NIB_W'(1);
  assign word_shift = word_q << 4;
  assign state_dbg  = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      trig_q         <= 1'b1;
      trig_prev      <= 1'b1;
      page_reset_q   <= 1'b0;
      word_idx       <= '0;
      nib_idx        <= '0;
      wait_cnt       <= '0;
      word_q         <= '0;
      mem_rd_en_out  <= 1'b0;
      mem_addr_out   <= '0;
      char_valid_out <= 1'b0;
      char_data_out  <= 8'h00;
      char_last_out  <= 1'b0;
      busy_out       <= 1'b0;
      page_addr_out  <= BASE_ADDR;
    end else begin
      trig_q        <= trigger_in;
      trig_prev     <= trig_q;
      page_reset_q  <= page_reset_in;
      mem_rd_en_out <= 1'b0;
      case (state)
        S_IDLE: begin
          if (trig_edge) begin
            state         <= S_REQ;
            busy_out      <= 1'b1;
            word_idx      <= '0;
            mem_addr_out  <= page_addr_out;
            mem_rd_en_out <= 1'b1;
          end else if (page_reset_q) begin
            page_addr_out <= BASE_ADDR;
          end
        end
        S_REQ: begin
          state    <= S_WAIT;
          wait_cnt <= '0;
        end
        S_WAIT: begin
          if (wait_cnt == LAST_WAIT) begin
            state          <= S_EMIT;
            word_q         <= mem_data_in;
            nib_idx        <= '0;
            char_valid_out <= 1'b1;
            char_data_out  <= hex_char(mem_data_in[DATA_WIDTH-1 -: 4]);
            char_last_out  <= last_word && (LAST_NIB == '0);
          end else begin
            wait_cnt <= wait_cnt + LAT_W'(1);
          end
        end
        S_EMIT: begin
          if (char_ready_in) begin
            if (last_nib) begin
              char_valid_out <= 1'b0;
              char_last_out  <= 1'b0;
              if (last_word) begin
                state         <= S_IDLE;
                busy_out      <= 1'b0;
                page_addr_out <= page_addr_out + PAGE_INC;
              end else begin
                state         <= S_REQ;
                word_idx      <= word_idx + WIDX_W'(1);
                mem_addr_out  <= mem_addr_out + STEP_A;
                mem_rd_en_out <= 1'b1;
              end
            end else begin
              nib_idx       <= nib_inc;
              word_q        <= word_shift;
              char_data_out <= hex_char(word_shift[DATA_WIDTH-1 -: 4]);
              char_last_out <= last_word && (nib_inc == LAST_NIB);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_page_reader.sv
// Directed bench for mem_page_reader: a default-parameter instance and a narrow
// 8-bit-address, 3-cycle-latency instance, each with a memory model and scoreboard.
module tb_mem_page_reader;

  localparam logic [31:0] POISON = 32'h0BAD0BAD;

  logic clk;
  logic rst;

  // Instance 0: default parameters
  logic        trig0, preset0, rd0, valid0, last0, ready0, busy0;
  logic [31:0] addr0, data0, page0;
  logic [7:0]  char0;
  logic [1:0]  st0;

  // Instance 1: ADDR_WIDTH=8, ADDR_STEP=4, WORDS_PER_PAGE=2, BASE=F8, latency 3
  logic        trig1, preset1, rd1, valid1, last1, ready1, busy1;
  logic [7:0]  addr1, page1;
  logic [31:0] data1, p1_a, p1_b;
  logic [7:0]  char1;
  logic [1:0]  st1;

  int checks   = 0;
  int failures = 0;
  int acc0     = 0;
  int rd_cnt0  = 0;
  bit bp0      = 1'b0;

  logic [7:0]  exp_q0[$];
  logic        exp_last_q0[$];
  logic [31:0] exp_addr_q0[$];
  logic [7:0]  exp_q1[$];
  logic        exp_last_q1[$];
  logic [31:0] exp_addr_q1[$];

  mem_page_reader u_dut (
    .clk(clk), .rst(rst), .trigger_in(trig0), .page_reset_in(preset0),
    .mem_rd_en_out(rd0), .mem_addr_out(addr0), .mem_data_in(data0),
    .char_valid_out(valid0), .char_data_out(char0), .char_last_out(last0),
    .char_ready_in(ready0), .busy_out(busy0), .page_addr_out(page0),
    .state_dbg(st0)
  );

  mem_page_reader #(
    .ADDR_WIDTH(8), .DATA_WIDTH(32), .WORDS_PER_PAGE(2), .ADDR_STEP(4),
    .BASE_ADDR(8'hF8), .MEM_LATENCY(3)
  ) u_dut_p (
    .clk(clk), .rst(rst), .trigger_in(trig1), .page_reset_in(preset1),
    .mem_rd_en_out(rd1), .mem_addr_out(addr1), .mem_data_in(data1),
    .char_valid_out(valid1), .char_data_out(char1), .char_last_out(last1),
    .char_ready_in(ready1), .busy_out(busy1), .page_addr_out(page1),
    .state_dbg(st1)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- memory models ----------------
  function automatic logic [31:0] mem_val0(input logic [31:0] a);
    case (a)
      32'd0:   return 32'hDEADBEEF;
      32'd1:   return 32'h00000001;
      32'd2:   return 32'h0000000A;
      32'd3:   return 32'hFFFFFFFF;
      default: return a * 32'h01010101 + 32'h13579BDF;
    endcase
  endfunction

  function automatic logic [31:0] mem_val1(input logic [7:0] a);
    return {a, 8'h3C, ~a, 8'h69};
  endfunction

  // Data is valid only in the cycle exactly MEM_LATENCY after the pulse.
  always @(posedge clk) begin
    data0 <= rd0 ? mem_val0(addr0) : POISON;
    p1_a  <= rd1 ? mem_val1(addr1) : POISON;
    p1_b  <= p1_a;
    data1 <= p1_b;
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] to_ascii(input logic [3:0] n);
    if (n <= 4'd9) return "0" + {4'h0, n};
    return "A" + ({4'h0, n} - 8'd10);
  endfunction

  task automatic push_word(input bit sel, input logic [31:0] val, input bit last_word);
    for (int k = 7; k >= 0; k--) begin
      if (!sel) begin
        exp_q0.push_back(to_ascii(val[k*4 +: 4]));
        exp_last_q0.push_back(last_word && (k == 0));
      end else begin
        exp_q1.push_back(to_ascii(val[k*4 +: 4]));
        exp_last_q1.push_back(last_word && (k == 0));
      end
    end
  endtask

  task automatic push_page0(input logic [31:0] base);
    for (int w = 0; w < 4; w++) begin
      exp_addr_q0.push_back(base + 32'(w));
      push_word(1'b0, mem_val0(base + 32'(w)), w == 3);
    end
  endtask

  task automatic push_page1(input logic [7:0] base);
    for (int w = 0; w < 2; w++) begin
      exp_addr_q1.push_back({24'h0, base + 8'(4 * w)});
      push_word(1'b1, mem_val1(base + 8'(4 * w)), w == 1);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done0(input string tag);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while ((busy0 || exp_q0.size() != 0) && n < 3000);
    chk({tag, "_in_time"}, n < 3000, 1'b1);
    chk({tag, "_chars_left"}, exp_q0.size(), 0);
    chk({tag, "_rd_left"}, exp_addr_q0.size(), 0);
  endtask

  task automatic wait_done1(input string tag);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while ((busy1 || exp_q1.size() != 0) && n < 3000);
    chk({tag, "_in_time"}, n < 3000, 1'b1);
    chk({tag, "_chars_left"}, exp_q1.size(), 0);
    chk({tag, "_rd_left"}, exp_addr_q1.size(), 0);
  endtask

  // ---------------- ready driver ----------------
  initial begin
    ready0 = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ready0 = bp0 ? ($urandom_range(0, 2) == 0) : 1'b1;
    end
  end

  // ---------------- monitors / scoreboards ----------------
  logic       pv0, pr0, pl0, pv1, pr1, pl1;
  logic [7:0] pd0, pd1;

  always @(negedge clk) begin
    if (rst) begin
      pv0 = 1'b0;
      pv1 = 1'b0;
    end else begin
      if (pv0 && !pr0) begin
        chk("hold_valid0", valid0, 1'b1);
        chk("hold_data0", char0, pd0);
        chk("hold_last0", last0, pl0);
      end
      chk("last_qual0", last0 && !valid0, 1'b0);
      if (valid0 && ready0) begin
        chk("char_expected0", exp_q0.size() > 0, 1'b1);
        if (exp_q0.size() > 0) begin
          chk("char0", char0, exp_q0.pop_front());
          chk("last0", last0, exp_last_q0.pop_front());
        end
        acc0++;
      end
      if (rd0) begin
        chk("rd_expected0", exp_addr_q0.size() > 0, 1'b1);
        if (exp_addr_q0.size() > 0) chk("rd_addr0", addr0, exp_addr_q0.pop_front());
        rd_cnt0++;
      end
      pv0 = valid0; pr0 = ready0; pd0 = char0; pl0 = last0;

      if (pv1 && !pr1) begin
        chk("hold_valid1", valid1, 1'b1);
        chk("hold_data1", char1, pd1);
      end
      chk("last_qual1", last1 && !valid1, 1'b0);
      if (valid1 && ready1) begin
        chk("char_expected1", exp_q1.size() > 0, 1'b1);
        if (exp_q1.size() > 0) begin
          chk("char1", char1, exp_q1.pop_front());
          chk("last1", last1, exp_last_q1.pop_front());
        end
      end
      if (rd1) begin
        chk("rd_expected1", exp_addr_q1.size() > 0, 1'b1);
        if (exp_addr_q1.size() > 0) chk("rd_addr1", {24'h0, addr1}, exp_addr_q1.pop_front());
      end
      pv1 = valid1; pr1 = ready1; pd1 = char1; pl1 = last1;
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    string s;
    int start, n, rd_base;
    rst = 1'b1;
    trig0 = 1'b0; preset0 = 1'b0;
    trig1 = 1'b0; preset1 = 1'b0; ready1 = 1'b1;
    repeat (3) step();

    // Reset state
    chk("rst_valid0", valid0, 1'b0);
    chk("rst_rd0", rd0, 1'b0);
    chk("rst_busy0", busy0, 1'b0);
    chk("rst_page0", page0, 32'h0);
    chk("rst_addr0", addr0, 32'h0);
    chk("rst_char0", char0, 8'h00);
    chk("rst_state0", st0, 2'd0);
    chk("rst_page1", page1, 8'hF8);
    rst = 1'b0;
    repeat (2) step();

    // Test 1: known page, ready held high, latency of first character
    s = "DEADBEEF000000010000000AFFFFFFFF";
    for (int i = 0; i < 32; i++) begin
      exp_q0.push_back(s[i]);
      exp_last_q0.push_back(i == 31);
    end
    for (int i = 0; i < 4; i++) exp_addr_q0.push_back(32'(i));
    trig0 = 1'b1;
    step();
    chk("lat_busy_e0", busy0, 1'b0);
    chk("lat_valid_e0", valid0, 1'b0);
    step();
    chk("lat_busy_e1", busy0, 1'b1);
    chk("lat_rd_e1", rd0, 1'b1);
    step();
    chk("lat_rd_e2", rd0, 1'b0);
    chk("lat_valid_e2", valid0, 1'b0);
    step();
    chk("lat_valid_e3", valid0, 1'b1);
    chk("lat_char_e3", char0, "D");
    chk("lat_state_e3", st0, 2'd3);
    wait_done0("t1");
    chk("t1_page", page0, 32'd4);
    chk("t1_rd_pulses", rd_cnt0, 4);
    trig0 = 1'b0;
    repeat (2) step();

    // Test 2: random backpressure on page 4..7
    bp0 = 1'b1;
    push_page0(32'd4);
    trig0 = 1'b1;
    wait_done0("t2");
    chk("t2_page", page0, 32'd8);
    bp0 = 1'b0;
    trig0 = 1'b0;
    repeat (2) step();

    // Test 3: held trigger fires once; edges and page reset ignored while busy
    push_page0(32'd8);
    trig0 = 1'b1;
    repeat (100) step();
    chk("t3_hold_chars", exp_q0.size(), 0);
    chk("t3_hold_page", page0, 32'd12);
    chk("t3_hold_busy", busy0, 1'b0);
    trig0 = 1'b0;
    repeat (2) step();
    rd_base = rd_cnt0;
    push_page0(32'd12);
    trig0 = 1'b1;
    repeat (4) step();
    chk("t3_busy", busy0, 1'b1);
    trig0 = 1'b0;
    step();
    trig0 = 1'b1;
    preset0 = 1'b1;
    step();
    preset0 = 1'b0;
    wait_done0("t3");
    repeat (10) step();
    chk("t3_page", page0, 32'd16);
    chk("t3_rd_pulses", rd_cnt0 - rd_base, 4);
    trig0 = 1'b0;
    repeat (2) step();
    push_page0(32'd16);
    trig0 = 1'b1;
    wait_done0("t3_fresh");
    chk("t3_fresh_page", page0, 32'd20);
    trig0 = 1'b0;
    repeat (2) step();

    // Test 4: page reset in idle, then trigger and page reset together
    preset0 = 1'b1;
    step();
    preset0 = 1'b0;
    repeat (2) step();
    chk("t4_page_reset", page0, 32'd0);
    push_page0(32'd0);
    trig0 = 1'b1;
    wait_done0("t4_a");
    chk("t4_page_a", page0, 32'd4);
    trig0 = 1'b0;
    repeat (2) step();
    push_page0(32'd4);
    trig0 = 1'b1;
    preset0 = 1'b1;
    repeat (2) step();
    preset0 = 1'b0;
    wait_done0("t4_b");
    chk("t4_page_b", page0, 32'd8);
    trig0 = 1'b0;
    repeat (2) step();

    // Test 5: narrow instance, address wrap and 3-cycle memory latency
    push_page1(8'hF8);
    trig1 = 1'b1;
    repeat (4) step();
    chk("t5_valid_e3", valid1, 1'b0);
    step();
    chk("t5_valid_e4", valid1, 1'b0);
    step();
    chk("t5_valid_e5", valid1, 1'b1);
    wait_done1("t5_a");
    chk("t5_page_a", page1, 8'h00);
    trig1 = 1'b0;
    repeat (2) step();
    push_page1(8'h00);
    trig1 = 1'b1;
    wait_done1("t5_b");
    chk("t5_page_b", page1, 8'h08);

    // Test 6: reset in the middle of a page with trigger held high
    push_page0(32'd8);
    start = acc0;
    trig0 = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (acc0 < start + 5 && n < 500);
    chk("t6_reach_chars", n < 500, 1'b1);
    rst = 1'b1;
    exp_q0.delete();
    exp_last_q0.delete();
    exp_addr_q0.delete();
    step();
    chk("t6_valid", valid0, 1'b0);
    chk("t6_busy", busy0, 1'b0);
    chk("t6_page", page0, 32'h0);
    chk("t6_rd", rd0, 1'b0);
    chk("t6_last", last0, 1'b0);
    chk("t6_state", st0, 2'd0);
    chk("t6_page1", page1, 8'hF8);
    rst = 1'b0;
    rd_base = rd_cnt0;
    repeat (20) step();
    chk("t6_no_fire_busy", busy0, 1'b0);
    chk("t6_no_fire_rd", rd_cnt0 - rd_base, 0);
    chk("t6_no_fire_page", page0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
